// File: rtl/kab_key_debouncer.sv
// Kabeta N-channel key conditioner: 2-flop sync, per-key debounce FSM, sticky press flags, irq.
// Optional hold-to-repeat events are compiled in when KEY_AUTOREPEAT_EN is defined.
module kab_key_debouncer #(
  parameter int NUM_KEYS        = 9,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_KEYS-1:0] ack,
  output logic [NUM_KEYS-1:0] keyState,
  output logic [NUM_KEYS-1:0] pressPend,
  output logic                irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] RELEASED_RAW = KEY_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } keyFsm_t;

  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : gBadNumKeys
    $error("kab_key_debouncer: NUM_KEYS must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : gBadDebounce
    $error("kab_key_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadRepeat
    $error("kab_key_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_KEYS-1:0] syncA;
  logic [NUM_KEYS-1:0] syncB;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] pendNext;

  // Synchroniser idles at the released raw level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncA <= RELEASED_RAW;
      syncB <= RELEASED_RAW;
    end else begin
      syncA <= keys;
      syncB <= syncA;
    end
  end

  assign pressed = KEY_ACTIVE_LOW ? ~syncB : syncB;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
    keyFsm_t       state;
    keyFsm_t       stateNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic [CW-1:0] cntInc;
    logic          level;
    logic          levelNext;
    logic          pressEvent;
    logic          repeatEvent;
    logic          pend;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        state <= stateNext;
        cnt   <= cntNext;
        level <= levelNext;
      end
    end

    // Any sample disagreeing with the pending direction restarts the window from zero.
    always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      levelNext  = level;
      pressEvent = 1'b0;
      cntInc     = cnt + CW'(1);
      case (state)
        IDLE: begin
          if (pressed[k]) begin
            stateNext = PRESS_WAIT;
            cntNext   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed[k]) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else if (cntInc == CNT_LAST) begin
            stateNext  = HELD;
            cntNext    = '0;
            levelNext  = 1'b1;
            pressEvent = 1'b1;
          end else begin
            cntNext = cntInc;
          end
        end
        HELD: begin
          if (!pressed[k]) begin
            stateNext = RELEASE_WAIT;
            cntNext   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed[k]) begin
            stateNext = HELD;
            cntNext   = '0;
          end else if (cntInc == CNT_LAST) begin
            stateNext = IDLE;
            cntNext   = '0;
            levelNext = 1'b0;
          end else begin
            cntNext = cntInc;
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
          levelNext = 1'b0;
        end
      endcase
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rptCnt;
    logic [RW-1:0] rptCntNext;
    logic [RW-1:0] rptInc;
    logic          rptFirstDone;
    logic          rptFirstNext;
    logic          enterHeld;

    assign enterHeld = (stateNext == HELD) && (state != HELD);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rptCnt       <= '0;
        rptFirstDone <= 1'b0;
      end else begin
        rptCnt       <= rptCntNext;
        rptFirstDone <= rptFirstNext;
      end
    end

    // Repeat timer runs only while steadily held; release bounces pause it and re-entry restarts it.
    always_comb begin
      rptCntNext   = rptCnt;
      rptFirstNext = rptFirstDone;
      repeatEvent  = 1'b0;
      rptInc       = rptCnt + RW'(1);
      if (enterHeld) begin
        rptCntNext   = '0;
        rptFirstNext = 1'b0;
      end else if (state == HELD && pressed[k]) begin
        if (!rptFirstDone) begin
          if (rptInc == RW'(REPEAT_DELAY)) begin
            repeatEvent  = 1'b1;
            rptCntNext   = '0;
            rptFirstNext = 1'b1;
          end else begin
            rptCntNext = rptInc;
          end
        end else if (rptInc == RW'(REPEAT_PERIOD)) begin
          repeatEvent = 1'b1;
          rptCntNext  = '0;
        end else begin
          rptCntNext = rptInc;
        end
      end
    end
`else
    assign repeatEvent = 1'b0;
`endif

    // A new event beats an acknowledge landing on the same edge.
    assign pendNext[k] = (pend & ~ack[k]) | pressEvent | repeatEvent;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pend <= 1'b0;
      end else begin
        pend <= pendNext[k];
      end
    end

    assign keyState[k]  = level;
    assign pressPend[k] = pend;
  end

  // Registered so the interrupt line cannot glitch while flags set and clear together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |pendNext;
    end
  end

endmodule

// File: doc/kab_key_debouncer.md
# kab_key_debouncer

Parametrised N-channel push-button conditioner for the Kabeta I/O subsystem; next generation of the fixed 9-key input path driven by the SystemChip bench. Synchronises raw key lines, debounces each independently with a per-key state machine, exposes clean levels plus sticky press-event flags with write-one-to-clear acknowledge and a combined interrupt. Optional hold-to-repeat event generation is compile-time selectable.

## Interface
- NUM_KEYS, 9, number of independent key channels (1..32)
- DEBOUNCE_CYCLES, 1000000, cycles raw input must be stable before a level change is accepted (>=2)
- REPEAT_DELAY, 25000000, cycles held before first repeat event (>=1; used only with KEY_AUTOREPEAT_EN)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat events (>=1; used only with KEY_AUTOREPEAT_EN)
- KEY_ACTIVE_LOW, 1, 1: raw Keys bit 0 means pressed; 0: raw 1 means pressed
- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- Keys  in  NUM_KEYS  raw asynchronous key inputs
- Ack  in  NUM_KEYS  write-one-to-clear for PressPend, sampled each edge
- KeyState  out  NUM_KEYS  debounced level, 1 = pressed
- PressPend  out  NUM_KEYS  sticky press-event flags
- Irq  out  1  OR of PressPend

## Operation
- Per key: 2-flop synchroniser, polarity normalised so internal p=1 means pressed. Sync flops reset to released level.
- Per-key counter, width $clog2(DEBOUNCE_CYCLES+1); per-key FSM:
  - IDLE (KeyState=0): p=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: p=0 -> IDLE; else cnt++; on cnt==DEBOUNCE_CYCLES-1 -> HELD, KeyState<=1, press event.
  - HELD (KeyState=1): p=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT: p=1 -> HELD (no new event); else cnt++; on cnt==DEBOUNCE_CYCLES-1 -> IDLE, KeyState<=0.
- Any bounce restarts the debounce window from zero; no partial credit.
- PressPend[i]: set by press event of key i, cleared by Ack[i]=1. Same-edge set and Ack: set wins. Event while already set: stays 1, no counter.
- Irq = |PressPend, derived from registers only (glitch-free).
- Channels fully independent; simultaneous events on multiple keys all recorded on the same edge.
- Reset: all FSMs IDLE, counters 0, KeyState=0, PressPend=0, Irq=0, immediately on assertion, mid-window or not. Window restarts after release.

## Timing
- Raw change settled before edge 0 and held stable: sync output valid after edge 1; KeyState and PressPend update at edge DEBOUNCE_CYCLES+1 (total DEBOUNCE_CYCLES+2 edges incl. edge 0).
- Release latency identical.
- Ack at edge k clears PressPend visible after edge k; Irq falls same cycle if no other flag set.
- Reset deassertion: first functional edge is the next rising edge; users synchronise deassertion upstream.

## Configuration
- KEY_AUTOREPEAT_EN defined: per-key repeat counter, cleared on every entry to HELD (including bounce return from RELEASE_WAIT). While HELD, repeat event (sets PressPend) when repeat counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles. RELEASE_WAIT pauses it; return to HELD restarts from zero.
- Not defined: repeat logic absent, REPEAT_* ignored; exactly one event per debounced press.

## Test plan
Use NUM_KEYS=9, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1.
- Clean press: Keys[0]=0 before edge 0 for 20 cycles -> KeyState[0]=1, PressPend[0]=1, Irq=1 after edge 5; release -> KeyState[0]=0 after 6 edges, PressPend[0] still 1.
- Bounce: Keys[3] low 3 cycles / high 1 cycle, repeated 10x -> KeyState[3]=0, PressPend[3]=0, Irq=0 throughout.
- Ack race: Ack[5]=1 on the edge key 5 event fires -> PressPend[5]=1; Ack[5]=1 next edge alone -> PressPend[5]=0, Irq=0.
- Async reset mid-PRESS_WAIT of key 2 (cnt=2), asserted between edges -> all outputs 0 immediately; after deassert key must be stable 6 further edges before KeyState[2]=1.
- Simultaneous: Keys[1] and Keys[2] low at same edge -> both PressPend bits set on same edge, Ack[1] alone leaves PressPend[2]=1, Irq=1.
- Repeat (macro on): hold key 8 40 cycles, Ack each event -> events at HELD entry, +10, +13, +16, ...; macro off -> single event only.
